// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_DATA,
    ST_WR,
    RMW_RD,
    RMW_WR,
    ERR
  } lsu_state_e;

  // True when the byte offset is illegal for the access size (reserved size included)
  function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: load extract/extend and store merge into an old word.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic [1:0]            offset,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] st_word
);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(32'h0000_00FF);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(32'h0000_FFFF);

  lsu_size_e             sz;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] lane;

  assign sz = lsu_size_e'(size);

  // Select the addressed lane, extend it, and build the merged store word
  always_comb begin
    shamt   = 5'd0;
    lane    = '0;
    ld_data = rdata;
    st_word = wdata;
    case (sz)
      SZ_BYTE: begin
        shamt   = {offset, 3'b000};
        lane    = rdata >> shamt;
        ld_data = {{(DATA_WIDTH-8){~is_unsigned & lane[7]}}, lane[7:0]};
        st_word = (rdata & ~(BYTE_MASK << shamt)) | ((wdata & BYTE_MASK) << shamt);
      end
      SZ_HALF: begin
        shamt   = {offset[1], 4'b0000};
        lane    = rdata >> shamt;
        ld_data = {{(DATA_WIDTH-16){~is_unsigned & lane[15]}}, lane[15:0]};
        st_word = (rdata & ~(HALF_MASK << shamt)) | ((wdata & HALF_MASK) << shamt);
      end
      default: begin
        ld_data = rdata;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a word-indexed data memory without byte enables.
// Sub-word stores are read-modify-write. Only DATA_WIDTH=32 is supported.
// Define LSU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS as errors.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state;
  logic [1:0]            lat_size;
  logic                  lat_unsigned;
  logic [DATA_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;
  logic                  oob_c;
  logic                  req_err_c;

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_c = (req_addr >> WORD_SHIFT) >= DATA_WIDTH'(MEM_WORDS);
`else
  logic [31:0] unused_mem_words;
  assign unused_mem_words = 32'(MEM_WORDS);
  assign oob_c = 1'b0;
`endif

  assign req_err_c = is_misaligned(lsu_size_e'(req_size), req_addr[1:0]) | oob_c;

  lsu_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .size        (lat_size),
    .offset      (lat_addr[1:0]),
    .is_unsigned (lat_unsigned),
    .rdata       (mem_rdata),
    .wdata       (lat_wdata),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  // Control FSM with latched request fields and registered handshake/response flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (req_err_c) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we) begin
              state <= LD_REQ;
            end else if (lsu_size_e'(req_size) == SZ_WORD) begin
              state      <= ST_WR;
              resp_valid <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LD_REQ: begin
          state      <= LD_DATA;
          resp_valid <= 1'b1;
        end
        RMW_RD: begin
          state      <= RMW_WR;
          resp_valid <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Memory strobes decode from state; reset kills them at once so an aborted RMW never writes
  assign mem_ren   = rst_n & ((state == LD_REQ) | (state == RMW_RD));
  assign mem_wen   = rst_n & ((state == ST_WR)  | (state == RMW_WR));
  assign mem_addr  = lat_addr >> WORD_SHIFT;
  assign mem_wdata = mem_wen ? st_word : '0;

  assign resp_rdata = (state == LD_DATA) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: byte-array reference model, decoupled driver and monitor.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DATA_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Attached memory: 256 words, registered read, index wraps
  logic [31:0] dmem [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_wen) dmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= dmem[mem_addr[7:0]];
  end

  // Reference model: flat byte memory (1 KiB image of the wrapped word space)
  logic [7:0] ref_bytes [1024] = '{default: 8'h0};

  typedef struct { logic err; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  exp_t        exp_q [$];
  int          acc_q [$];
  logic [31:0] rd_q  [$];
  wr_t         wr_q  [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] idx);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(ref_bytes[{idx, 2'(k)}]) << (8 * k));
    return w;
  endfunction

  // Monitor: checks every memory access and response against the queued expectations
  exp_t        mon_e;
  int          mon_acc;
  wr_t         mon_w;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen || mem_ren) chk("wen_ren_exclusive", {31'b0, mem_wen & mem_ren}, 32'd0);
      if (mem_ren) begin
        chk("wdata_zero_on_read", mem_wdata, 32'd0);
        if (rd_q.size() == 0) fail_now("unexpected_mem_ren");
        else chk("mem_ren_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_wen) begin
        if (wr_q.size() == 0) fail_now("unexpected_mem_wen");
        else begin
          mon_w = wr_q.pop_front();
          chk("mem_wen_addr", mem_addr, mon_w.addr);
          chk("mem_wdata", mem_wdata, mon_w.data);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("unexpected_resp_valid");
        else begin
          mon_e   = exp_q.pop_front();
          mon_acc = acc_q.pop_front();
          chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_latency", 32'(cyc - mon_acc + 1), 32'(mon_e.lat));
        end
      end
    end
  end

  // Driver: wait for ready, present one request, record model expectations
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit abort);
    int          n;
    int          k;
    logic        err;
    logic [31:0] v;
    logic [9:0]  bi;
    exp_t        e;
    wr_t         w;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      return;
    end
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    if ((a >> 2) >= 32'd256) err = 1'b1;
`endif
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (err) begin
      e = '{1'b1, 32'h0, 1};
    end else if (!we) begin
      v = '0;
      for (int j = 0; j < n; j++) begin
        bi = a[9:0] + 10'(j);
        v  = v | (32'(ref_bytes[bi]) << (8 * j));
      end
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e = '{1'b0, v, 2};
      rd_q.push_back(a >> 2);
    end else begin
      if (n < 4) rd_q.push_back(a >> 2);
      if (!abort) begin
        for (int j = 0; j < n; j++) begin
          bi = a[9:0] + 10'(j);
          ref_bytes[bi] = wd[8*j +: 8];
        end
        w.addr = a >> 2;
        w.data = ref_word(a[9:2]);
        wr_q.push_back(w);
      end
      e = '{1'b0, 32'h0, (n < 4) ? 2 : 1};
    end
    if (!abort) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!abort) acc_q.push_back(cyc);
    req_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store then load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    // Byte RMW into 0x11223344
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFFAA, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    // Extension cases on 0x8000FF7F
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000FF7F, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
    // Errors: misaligned half/word, reserved size
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h55, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset during the write cycle of a byte RMW
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rmw_mem_wen", {31'b0, mem_wen}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rmw_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_rmw_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_rmw_resp_valid", {31'b0, resp_valid}, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Out-of-range index
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0);

    // Fill the low region, then random traffic
    for (int i = 0; i < 64; i++) issue(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      if ($urandom_range(0, 15) == 0) a = a | 32'h400;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    repeat (6) @(negedge clk);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem_image[%0d]", i), dmem[i], ref_word(8'(i)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Initiator side of the data-memory port: the load/store unit between the execute stage and the word-indexed data memory.
- Accepts byte/half/word loads and stores on byte addresses.
- Converts each request into word-index memory accesses and sign- or zero-extends load data.
- The memory has no byte enables, so sub-word stores use read-modify-write.

Parameters:
- DATA_WIDTH, 32, datapath and address width; only 32 supported.
- MEM_WORDS, 256, number of words in the attached data memory; used by the optional bounds check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  input  DATA_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse; no backpressure
- resp_err  output  1  qualifies resp_valid: misaligned, reserved size, or out of bounds
- resp_rdata  output  DATA_WIDTH  extended load data, valid with resp_valid on loads; 0 otherwise
- mem_wen  output  1  memory write enable
- mem_ren  output  1  memory read enable
- mem_addr  output  DATA_WIDTH  word index = latched addr >> 2, zero-extended
- mem_wdata  output  DATA_WIDTH  full word to write
- mem_rdata  input  DATA_WIDTH  memory read data, registered one cycle after mem_ren

Behaviour:
- Handshake: request accepted when req_valid && req_ready. On accept, all req_* fields are latched. req_ready=0 until the FSM returns to IDLE.
- FSM states: IDLE, LD_REQ, LD_DATA, ST_WR, RMW_RD, RMW_WR, ERR.
- IDLE, accepting a request:
  - Error (addr[0]!=0 for half; addr[1:0]!=0 for word; size 11) -> ERR.
  - Load -> LD_REQ.
  - Word store -> ST_WR.
  - Byte/half store -> RMW_RD.
- LD_REQ: mem_ren=1 -> LD_DATA.
- LD_DATA: extract lane from mem_rdata; resp_valid=1; resp_rdata extended -> IDLE.
- ST_WR: mem_wen=1, mem_wdata=latched wdata, resp_valid=1 -> IDLE.
- RMW_RD: mem_ren=1 -> RMW_WR.
- RMW_WR: mem_wen=1; mem_wdata=mem_rdata with the target lane replaced; resp_valid=1 -> IDLE.
- ERR: resp_valid=1, resp_err=1; no memory access -> IDLE.
- Latency from accept to resp_valid: word store 1, error 1, load 2, sub-word store 2. Next request can be accepted the cycle after resp_valid.
- Lanes are little-endian:
  - Byte lane = addr[1:0], bits [8*a+7:8*a].
  - Half lane = addr[1], bits [16*h+15:16*h].
  - Store data is taken from the low bits of req_wdata.
- mem_wen and mem_ren are never high together. Both are 0 in IDLE.
- Memory outputs are combinational from state and latched fields. mem_wdata=0 when mem_wen=0.
- Reset: while rst_n=0, mem_wen and mem_ren are forced 0 combinationally, so an in-flight RMW never writes. Next state is IDLE and latches clear.
- Reset values: req_ready=1 (after reset deasserts), resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0.
- req_valid while busy is ignored; the requester holds it until ready.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: word index (addr>>2) >= MEM_WORDS is treated as an error. The request takes the ERR path with resp_err=1 and no memory access.
- Undefined: no range check; mem_addr passes the full index and the memory wraps or ignores it.

Decomposition:
- Package lsu_pkg:
  - enum lsu_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}
  - enum lsu_state_e
  - constant WORD_SHIFT=2
- Sub-module lsu_byte_lane: purely combinational.
  - Load path: extract plus sign/zero extend.
  - Store path: merge old word, new data, size and offset.
- Top module holds the FSM and the latches.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10 -> resp 1 cycle later; mem[4]=0xDEADBEEF. Load word @0x10 -> resp_rdata=0xDEADBEEF 2 cycles after accept.
- Byte store RMW: mem[4]=0x11223344; store byte 0xAA @0x12 -> mem_ren then mem_wen with mem_wdata=0x11AA3344; resp_err=0.
- Load extension, mem[4]=0x8000FF7F:
  - signed byte @0x10 -> 0x0000007F
  - signed byte @0x11 -> 0xFFFFFFFF
  - unsigned half @0x12 -> 0x00008000
  - signed half @0x12 -> 0xFFFF8000
- Misaligned: half @0x13 and word @0x12 -> resp_valid and resp_err=1 one cycle after accept. No mem_wen/mem_ren ever asserts; mem unchanged. Size 11 gives the same result.
- Reset mid-RMW: assert rst_n=0 in the RMW_WR cycle of a byte store -> mem_wen stays 0; mem word unchanged; req_ready=1 after release.
- With LSU_BOUNDS_CHECK_EN, MEM_WORDS=256: load @0x400 -> resp_err=1, no mem_ren. Without the macro: mem_ren asserts with mem_addr=0x100.
